fetch_prefetch_unit: RTL and testbench

- Next-generation instruction fetch stage with three parts: a streaming program loader, a word-addressed instruction memory, and a prefetch queue.
- The loader fills memory from a byte stream (UART boot path) instead of a file image.
- The fetch side streams {instr, pc} pairs to decode over a valid/ready handshake.
- Supports branch redirect with queue flush, issue stall, and an address-fault report. Sits between the boot UART and the decode stage.

---
 rtl/fetch_prefetch_unit.sv | 165 ++++++++++++++++
 tb/tb_fetch_prefetch_unit.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch stage: byte-stream program loader, word-addressed instruction
// memory and a show-ahead prefetch queue feeding decode with {instr, pc} pairs.
module fetch_prefetch_unit #(
  parameter int unsigned     XLEN         = 32,
  parameter int unsigned     MEM_WORDS    = 64,
  parameter int unsigned     FIFO_DEPTH   = 4,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ld_valid,
  input  logic [7:0]      ld_byte,
  input  logic            ld_last,
  output logic            ld_ready,
  output logic            ld_done,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_addr,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic            fault
);

  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam int unsigned QW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = QW + 1;

  typedef enum logic [1:0] {ST_LOAD, ST_RUN, ST_FAULT} state_t;

  state_t          state, state_next;

  logic [XLEN-1:0] mem [MEM_WORDS];
  logic [1:0]      byte_cnt;
  logic [AW-1:0]   word_cnt;
  logic [XLEN-1:0] ld_buf, ld_word;
  logic            ld_accept, ld_wr;

  logic [XLEN-1:0] pc;
  logic [AW-1:0]   pc_idx;
  logic            pc_legal, issue, pop, redir_take;

  logic [XLEN-1:0] q_instr [FIFO_DEPTH];
  logic [XLEN-1:0] q_pc    [FIFO_DEPTH];
  logic [QW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;

  assign ld_ready    = (state == ST_LOAD);
  assign ld_done     = (state != ST_LOAD);
  assign fault       = (state == ST_FAULT);
  assign instr_valid = (count != '0);
  assign instr       = instr_valid ? q_instr[rd_ptr] : '0;
  assign instr_pc    = instr_valid ? q_pc[rd_ptr] : '0;

  assign ld_accept  = ld_valid && (state == ST_LOAD) && !rst;
  assign ld_wr      = ld_accept && ((byte_cnt == 2'd3) || ld_last);
  assign redir_take = redirect && (state != ST_LOAD);

  // Legal fetch address: word aligned and inside the instruction memory.
  assign pc_idx   = pc[AW+1:2];
  assign pc_legal = (pc[1:0] == 2'b00) && (pc[XLEN-1:AW+2] == '0);
  assign issue    = (state == ST_RUN) && !redirect && !stall && pc_legal &&
                    (count < CW'(FIFO_DEPTH));
  assign pop      = instr_valid && instr_ready;

  // Incoming byte lands MSB first; bytes not yet received stay zero for padding.
  always_comb begin
    ld_word = ld_buf;
    case (byte_cnt)
      2'd0:    ld_word[XLEN-1  -: 8] = ld_byte;
      2'd1:    ld_word[XLEN-9  -: 8] = ld_byte;
      2'd2:    ld_word[XLEN-17 -: 8] = ld_byte;
      default: ld_word[XLEN-25 -: 8] = ld_byte;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_LOAD;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_LOAD: begin
        if (ld_wr && (ld_last || (word_cnt == AW'(MEM_WORDS - 1)))) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (redirect) begin
          state_next = ST_RUN;
        end else if (!pc_legal) begin
          state_next = ST_FAULT;
        end
      end
      ST_FAULT: begin
        if (redirect) begin
          state_next = ST_RUN;
        end
      end
      default: state_next = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (ld_wr) begin
      mem[word_cnt] <= ld_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt <= '0;
      word_cnt <= '0;
      ld_buf   <= '0;
    end else if (ld_accept) begin
      if (ld_wr) begin
        byte_cnt <= '0;
        word_cnt <= word_cnt + 1'b1;
        ld_buf   <= '0;
      end else begin
        byte_cnt <= byte_cnt + 1'b1;
        ld_buf   <= ld_word;
      end
    end
  end

  // Fetch pointer and queue bookkeeping; redirect flushes and drops any same-cycle pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= RESET_VECTOR;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redir_take) begin
      pc     <= redirect_addr;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (issue) begin
        pc     <= pc + XLEN'(4);
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(issue) - CW'(pop);
    end
  end

  // The memory read completes within the issue cycle and lands in the queue at its end.
  always_ff @(posedge clk) begin
    if (issue) begin
      q_instr[wr_ptr] <= mem[pc_idx];
      q_pc[wr_ptr]    <= pc;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Self-checking bench for fetch_prefetch_unit: queue-based reference model compared
// every cycle, plus literal expectations for the directed scenarios.
module tb_fetch_prefetch_unit;

  localparam int unsigned MEM_WORDS  = 64;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int S_LOAD  = 0;
  localparam int S_RUN   = 1;
  localparam int S_FAULT = 2;

  logic        clk;
  logic        rst;
  logic        ld_valid;
  logic [7:0]  ld_byte;
  logic        ld_last;
  logic        ld_ready;
  logic        ld_done;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        fault;

  fetch_prefetch_unit #(
    .XLEN(32), .MEM_WORDS(MEM_WORDS), .FIFO_DEPTH(FIFO_DEPTH), .RESET_VECTOR(32'h0)
  ) dut (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_last(ld_last),
    .ld_ready(ld_ready), .ld_done(ld_done),
    .stall(stall), .redirect(redirect), .redirect_addr(redirect_addr),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  int          m_state = S_LOAD;
  logic [31:0] m_pc;
  logic [31:0] mem_m [MEM_WORDS];
  int          m_words;
  logic [7:0]  bq [$];
  logic [31:0] mq_i [$];
  logic [31:0] mq_p [$];
  logic [31:0] w;
  bit          take, legal, go, armed = 0;

  // Accepted {instr, pc} pairs as seen on the decode interface
  logic [31:0] ob_i [$];
  logic [31:0] ob_p [$];

  always @(posedge clk) begin
    if (rst) begin
      m_state = S_LOAD;
      m_pc    = 32'h0;
      m_words = 0;
      bq.delete();
      mq_i.delete();
      mq_p.delete();
      armed   = 1;
    end else if (m_state == S_LOAD) begin
      if (ld_valid) begin
        bq.push_back(ld_byte);
        if (bq.size() == 4 || ld_last) begin
          w = 32'h0;
          for (int i = 0; i < 4; i++) w = {w[23:0], (i < bq.size()) ? bq[i] : 8'h00};
          mem_m[m_words] = w;
          m_words++;
          bq.delete();
          if (ld_last || m_words == MEM_WORDS) m_state = S_RUN;
        end
      end
    end else begin
      take = (mq_p.size() != 0) && instr_ready;
      if (redirect) begin
        mq_i.delete();
        mq_p.delete();
        m_pc    = redirect_addr;
        m_state = S_RUN;
      end else begin
        legal = (m_pc % 4 == 0) && (m_pc < 4 * MEM_WORDS);
        go    = (m_state == S_RUN) && !stall && legal && (mq_p.size() < FIFO_DEPTH);
        if (take) begin
          void'(mq_i.pop_front());
          void'(mq_p.pop_front());
        end
        if (go) begin
          mq_i.push_back(mem_m[m_pc / 4]);
          mq_p.push_back(m_pc);
          m_pc = m_pc + 32'd4;
        end
        if (m_state == S_RUN && !legal) m_state = S_FAULT;
      end
    end
  end

  // Compare process: DUT outputs against the model once per cycle.
  always @(negedge clk) begin
    if (armed) begin
      chk("ld_ready", 32'(ld_ready), 32'(m_state == S_LOAD));
      chk("ld_done", 32'(ld_done), 32'(m_state != S_LOAD));
      chk("fault", 32'(fault), 32'(m_state == S_FAULT));
      chk("instr_valid", 32'(instr_valid), 32'(mq_p.size() != 0));
      if (mq_p.size() != 0) begin
        chk("instr", instr, mq_i[0]);
        chk("instr_pc", instr_pc, mq_p[0]);
      end else if (m_state == S_LOAD) begin
        chk("instr_idle", instr, 32'h0);
        chk("instr_pc_idle", instr_pc, 32'h0);
      end
      if (instr_valid && instr_ready && !rst && !(redirect && m_state != S_LOAD)) begin
        ob_i.push_back(instr);
        ob_p.push_back(instr_pc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    ob_i.delete();
    ob_p.delete();
  endtask

  task automatic load(input logic [7:0] b [$], input bit last, input bit noise);
    for (int i = 0; i < b.size(); i++) begin
      if (noise) begin
        while ($urandom_range(0, 3) == 0) begin
          ld_valid      = 1'b0;
          redirect      = 1'($urandom_range(0, 1));
          redirect_addr = $urandom;
          stall         = 1'($urandom_range(0, 1));
          step();
        end
      end
      ld_valid = 1'b1;
      ld_byte  = b[i];
      ld_last  = last && (i == b.size() - 1);
      if (noise) begin
        redirect      = 1'($urandom_range(0, 1));
        redirect_addr = $urandom;
        stall         = 1'($urandom_range(0, 1));
        instr_ready   = 1'($urandom_range(0, 1));
      end
      step();
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    redirect = 1'b0;
    stall    = 1'b0;
  endtask

  task automatic run_random(input int n, input int p_stall, input int p_redir);
    for (int i = 0; i < n; i++) begin
      instr_ready = 1'($urandom_range(0, 3) != 0);
      stall       = 1'($urandom_range(0, 99) < p_stall);
      redirect    = 1'($urandom_range(0, 99) < p_redir);
      case ($urandom_range(0, 7))
        0:       redirect_addr = $urandom;
        1:       redirect_addr = 32'($urandom_range(0, 260));
        2:       redirect_addr = 32'h100;
        default: redirect_addr = 32'($urandom_range(0, MEM_WORDS - 1) * 4);
      endcase
      step();
    end
    redirect = 1'b0;
    stall    = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] b [$];
    rst = 1'b1; ld_valid = 1'b0; ld_byte = 8'h0; ld_last = 1'b0;
    stall = 1'b0; redirect = 1'b0; redirect_addr = 32'h0; instr_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("reset_ld_ready", 32'(ld_ready), 32'd1);
    chk("reset_instr_valid", 32'(instr_valid), 32'd0);

    // Full-memory load without ld_last: writing the last word ends the load
    b.delete();
    for (int i = 0; i < 4 * MEM_WORDS; i++) b.push_back(8'($urandom));
    load(b, 1'b0, 1'b1);
    chk("full_load_done", 32'(ld_done), 32'd1);
    run_random(300, 10, 3);

    // Reset mid-stream returns everything to reset values
    instr_ready = 1'b1;
    step(); step();
    rst = 1'b1;
    step();
    chk("midrst_ld_ready", 32'(ld_ready), 32'd1);
    chk("midrst_ld_done", 32'(ld_done), 32'd0);
    chk("midrst_valid", 32'(instr_valid), 32'd0);
    chk("midrst_fault", 32'(fault), 32'd0);
    chk("midrst_instr_pc", instr_pc, 32'h0);
    rst = 1'b0;

    // Zero the memory, then load the two-instruction program
    b.delete();
    for (int i = 0; i < 4 * MEM_WORDS; i++) b.push_back(8'h00);
    load(b, 1'b1, 1'b0);
    do_reset();
    b = '{8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h10, 8'h00, 8'h93};
    instr_ready = 1'b1;
    load(b, 1'b1, 1'b0);
    chk("prog_ld_done", 32'(ld_done), 32'd1);
    chk("model_word0", mem_m[0], 32'h00000013);
    chk("model_word1", mem_m[1], 32'h00100093);
    for (int i = 0; i < 80; i++) step();
    chk("stream_count", 32'(ob_p.size()), 32'd64);
    if (ob_p.size() >= 64) begin
      chk("stream_i0", ob_i[0], 32'h00000013);
      chk("stream_p0", ob_p[0], 32'h0);
      chk("stream_i1", ob_i[1], 32'h00100093);
      chk("stream_p1", ob_p[1], 32'h4);
      chk("stream_i2", ob_i[2], 32'h0);
      chk("stream_p2", ob_p[2], 32'h8);
      chk("stream_last_pc", ob_p[63], 32'hFC);
    end
    chk("end_fault", 32'(fault), 32'd1);
    chk("end_valid", 32'(instr_valid), 32'd0);

    // Misaligned redirect clears the fault, then faults again
    redirect = 1'b1; redirect_addr = 32'h2;
    step();
    redirect = 1'b0;
    chk("mis_fault_clear", 32'(fault), 32'd0);
    step();
    chk("mis_fault_again", 32'(fault), 32'd1);

    // Redirect to 0 with decode stalled: queue fills to exactly FIFO_DEPTH
    redirect = 1'b1; redirect_addr = 32'h0; instr_ready = 1'b0;
    step();
    redirect = 1'b0;
    chk("r0_valid_t1", 32'(instr_valid), 32'd0);
    step();
    chk("r0_head_pc", instr_pc, 32'h0);
    for (int i = 0; i < 8; i++) step();
    chk("full_model_size", 32'(mq_p.size()), 32'd4);
    chk("full_head_pc", instr_pc, 32'h0);

    // Pop one without refill, then redirect with 3 entries queued
    instr_ready = 1'b1; stall = 1'b1;
    step();
    chk("three_model_size", 32'(mq_p.size()), 32'd3);
    chk("three_head_pc", instr_pc, 32'h4);
    instr_ready = 1'b0; stall = 1'b0; redirect = 1'b1; redirect_addr = 32'h20;
    step();
    redirect = 1'b0;
    chk("r20_valid_t1", 32'(instr_valid), 32'd0);
    step();
    chk("r20_valid_t2", 32'(instr_valid), 32'd1);
    chk("r20_head_pc", instr_pc, 32'h20);

    // Free-running stream with a 5-cycle stall in the middle
    instr_ready = 1'b1;
    for (int i = 0; i < 10; i++) step();
    stall = 1'b1;
    for (int i = 0; i < 5; i++) step();
    stall = 1'b0;
    for (int i = 0; i < 10; i++) step();

    // Partial final word is zero-padded
    do_reset();
    b = '{8'hAA, 8'hBB, 8'hCC};
    load(b, 1'b1, 1'b0);
    chk("model_partial", mem_m[0], 32'hAABBCC00);
    step(); step(); step();
    chk("partial_seen", 32'(ob_i.size() > 0), 32'd1);
    if (ob_i.size() > 0) begin
      chk("partial_word", ob_i[0], 32'hAABBCC00);
      chk("partial_pc", ob_p[0], 32'h0);
    end

    // Randomised program and traffic
    do_reset();
    b.delete();
    for (int i = 0, n = $urandom_range(100, 4 * MEM_WORDS); i < n; i++) b.push_back(8'($urandom));
    load(b, 1'b1, 1'b1);
    run_random(3000, 15, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
